// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target blocks.
//   State encoding for the target FSM, R/W bit values and ACK/NACK bus levels.
package i2c_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_ADDR      = 3'd1;
  localparam logic [STATE_W-1:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [STATE_W-1:0] ST_RX_DATA   = 3'd3;
  localparam logic [STATE_W-1:0] ST_RX_ACK    = 3'd4;
  localparam logic [STATE_W-1:0] ST_TX_DATA   = 3'd5;
  localparam logic [STATE_W-1:0] ST_TX_ACK    = 3'd6;
  localparam logic [STATE_W-1:0] ST_WAIT_STOP = 3'd7;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer and bus-event detector.
//   i_clk, i_rst : system clock, async active-high reset
//   scl_in       : raw bus clock
//   sda_in       : raw bus data
//   scl_rise     : one-cycle strobe, SCL went high
//   scl_fall     : one-cycle strobe, SCL went low
//   start_det    : one-cycle strobe, SDA fell while SCL high
//   stop_det     : one-cycle strobe, SDA rose while SCL high
//   sda_sync     : synchronized SDA level, aligned with the strobes
// Every output appears SYNC_STAGES+1 cycles after the bus change.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_pipe[SYNC_STAGES-1];
  assign sda_s = sda_pipe[SYNC_STAGES-1];

  // Chains reset to 1 (idle bus) so reset release never fakes a START.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_pipe  <= '1;
      sda_pipe  <= '1;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_sync  <= 1'b1;
    end else begin
      scl_pipe  <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
      sda_pipe  <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
      scl_prev  <= scl_s;
      sda_prev  <= sda_s;
      scl_rise  <= scl_s & ~scl_prev;
      scl_fall  <= ~scl_s & scl_prev;
      start_det <= sda_prev & ~sda_s & scl_s;
      stop_det  <= ~sda_prev & sda_s & scl_s;
      sda_sync  <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_slave_single_byte.sv
// I2C target answering SLAVE_ADDR for single-byte write and read transfers.
//   i_clk, i_rst : system clock, async active-high reset
//   i_enable     : 0 forces IDLE and releases SDA
//   i_tx_byte    : byte returned on a read, captured at address match
//   o_rx_byte    : last byte received in a write
//   o_rx_valid   : one-cycle pulse when o_rx_byte updates
//   o_tx_done    : one-cycle pulse once the master's ACK/NACK of the read byte is sampled
//   o_tx_acked   : master's response to the last read byte (1 = ACK)
//   o_busy       : high whenever the FSM is not IDLE
//   io_scl       : bus clock, input only
//   io_sda       : open-drain bus data, driven 0 or Z
module i2c_slave_single_byte
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_tx_done,
  output logic       o_tx_acked,
  output logic       o_busy,
  input  logic       io_scl,
  inout  wire        io_sda
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_sync;

  logic [STATE_W-1:0]   state_q,     state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q,     shift_d;
  logic                 byte_done_q, byte_done_d;
  logic                 rw_q,        rw_d;
  logic                 sda_low_q,   sda_low_d;
  logic [BYTE_W-1:0]    rx_byte_d;
  logic                 rx_valid_d;
  logic                 tx_done_d;
  logic                 tx_acked_d;
  logic                 busy_d;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .scl_in   (io_scl),
    .sda_in   (io_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_sync (sda_sync)
  );

  // Open-drain: only ever pull low.
  assign io_sda = sda_low_q ? 1'b0 : 1'bz;

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      rw_q        <= RW_WRITE;
      sda_low_q   <= 1'b0;
      o_rx_byte   <= '0;
      o_rx_valid  <= 1'b0;
      o_tx_done   <= 1'b0;
      o_tx_acked  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      sda_low_q   <= sda_low_d;
      o_rx_byte   <= rx_byte_d;
      o_rx_valid  <= rx_valid_d;
      o_tx_done   <= tx_done_d;
      o_tx_acked  <= tx_acked_d;
      o_busy      <= busy_d;
    end
  end

  // Next-state and output logic; priority enable > STOP > START > SCL strobes.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    sda_low_d   = sda_low_q;
    rx_byte_d   = o_rx_byte;
    rx_valid_d  = 1'b0;
    tx_done_d   = 1'b0;
    tx_acked_d  = o_tx_acked;

    if (!i_enable || stop_det) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
    end else if (start_det) begin
      state_d     = ST_ADDR;
      sda_low_d   = 1'b0;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (byte_done_q) begin
            if (scl_fall) begin
              sda_low_d = 1'b1;
              state_d   = ST_ADDR_ACK;
            end
          end else if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_sync};
            if (bit_cnt_q == 3'd7) begin
              // shift_q[6:0] already holds the 7 address bits; sda_sync is R/W.
              if (shift_q[6:0] == SLAVE_ADDR) begin
                rw_d        = sda_sync;
                shift_d     = i_tx_byte;
                byte_done_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q == RW_READ) begin
              state_d   = ST_TX_DATA;
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
            end else begin
              state_d   = ST_RX_DATA;
              sda_low_d = 1'b0;
            end
          end
        end

        ST_RX_DATA: begin
          if (byte_done_q) begin
            if (scl_fall) begin
              sda_low_d = 1'b1;
              state_d   = ST_RX_ACK;
            end
          end else if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_sync};
            if (bit_cnt_q == 3'd7) begin
              rx_byte_d   = {shift_q[6:0], sda_sync};
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            state_d   = ST_WAIT_STOP;
          end
        end

        // bit_cnt counts bits already presented; bit 7 went out on entry.
        ST_TX_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            tx_acked_d = (sda_sync == ACK);
            tx_done_d  = 1'b1;
            state_d    = ST_WAIT_STOP;
          end
        end

        ST_IDLE, ST_WAIT_STOP: begin
          sda_low_d = 1'b0;
        end

        default: begin
          state_d   = ST_IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end

    // Every state entry starts a fresh byte.
    if (state_d != state_q) begin
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_i2c_slave_single_byte.sv
// Bench for i2c_slave_single_byte: a bit-banged bus master drives randomized
// and directed transfers; expected rx bytes and read-ACK results go into
// queues that a monitor pops whenever the target pulses o_rx_valid / o_tx_done.
module tb_i2c_slave_single_byte;
  import i2c_pkg::*;

  localparam logic [6:0] SLV  = 7'h42;
  localparam int         HALF = 10;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_enable;
  logic [7:0] i_tx_byte;
  logic [7:0] o_rx_byte;
  logic       o_rx_valid;
  logic       o_tx_done;
  logic       o_tx_acked;
  logic       o_busy;
  logic       scl;
  logic       m_sda_low;
  wire        sda_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_single_byte #(
    .SLAVE_ADDR (SLV),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_enable  (i_enable),
    .i_tx_byte (i_tx_byte),
    .o_rx_byte (o_rx_byte),
    .o_rx_valid(o_rx_valid),
    .o_tx_done (o_tx_done),
    .o_tx_acked(o_tx_acked),
    .o_busy    (o_busy),
    .io_scl    (scl),
    .io_sda    (sda_bus)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] rx_q[$];
  logic       tx_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: pop expectations whenever the target presents a pulse.
  logic prev_rx = 1'b0;
  logic prev_tx = 1'b0;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_rx_valid || o_tx_done)
        check("pulse_exclusive", 32'(o_rx_valid & o_tx_done), 0);
      if (o_rx_valid && prev_rx) check("rx_valid_width", 2, 1);
      if (o_tx_done && prev_tx) check("tx_done_width", 2, 1);
      if (o_rx_valid && !prev_rx) begin
        if (rx_q.size() == 0) check("rx_unexpected", 32'(o_rx_byte), 32'hFFFF_FFFF);
        else check("rx_byte", 32'(o_rx_byte), 32'(rx_q.pop_front()));
      end
      if (o_tx_done && !prev_tx) begin
        if (tx_q.size() == 0) check("tx_unexpected", 32'(o_tx_acked), 32'hFFFF_FFFF);
        else check("tx_acked", 32'(o_tx_acked), 32'(tx_q.pop_front()));
      end
    end
    prev_rx = o_rx_valid;
    prev_tx = o_tx_done;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One SCL clock with SCL low on entry and exit; returns bus level mid-high.
  task automatic bit_xfer(input logic b, output logic r);
    clks(HALF / 2);
    m_sda_low = ~b;
    clks(HALF / 2);
    scl = 1'b1;
    clks(HALF / 2);
    r = sda_bus;
    clks(HALF / 2);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(master_ack ? ACK : NACK, r);
  endtask

  task automatic start_cond();
    if (!scl) begin
      clks(HALF / 2);
      m_sda_low = 1'b0;
      clks(HALF / 2);
      scl = 1'b1;
      clks(HALF);
    end
    m_sda_low = 1'b1;
    clks(HALF);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    clks(HALF / 2);
    m_sda_low = 1'b1;
    clks(HALF / 2);
    scl = 1'b1;
    clks(HALF);
    m_sda_low = 1'b0;
    clks(5);
    check("busy_after_stop", 32'(o_busy), 0);
    clks(HALF);
  endtask

  // Reference: target acks iff enabled and address matches; data byte acked likewise.
  task automatic do_write(input logic [6:0] addr, input logic [7:0] data);
    logic a;
    logic hit;
    hit = i_enable && (addr == SLV);
    start_cond();
    send_byte({addr, RW_WRITE}, a);
    check("write_addr_ack", 32'(a), 32'(hit ? ACK : NACK));
    if (hit) rx_q.push_back(data);
    send_byte(data, a);
    check("write_data_ack", 32'(a), 32'(hit ? ACK : NACK));
    stop_cond();
  endtask

  // Read after START already issued; i_tx_byte is scrambled once latched.
  task automatic read_body(input logic [7:0] txb, input logic mack);
    logic       a;
    logic [7:0] d;
    send_byte({SLV, RW_READ}, a);
    check("read_addr_ack", 32'(a), 32'(ACK));
    i_tx_byte = 8'($urandom);
    tx_q.push_back(mack);
    recv_byte(mack, d);
    check("read_data", 32'(d), 32'(txb));
    stop_cond();
  endtask

  task automatic do_read(input logic [7:0] txb, input logic mack);
    i_tx_byte = txb;
    start_cond();
    read_body(txb, mack);
  endtask

  initial begin
    logic       a;
    logic       r;
    logic [6:0] addr;
    int         kind;

    i_rst     = 1'b1;
    i_enable  = 1'b1;
    i_tx_byte = 8'h00;
    scl       = 1'b1;
    m_sda_low = 1'b0;
    #1;
    check("rst_rx_byte",  32'(o_rx_byte), 0);
    check("rst_rx_valid", 32'(o_rx_valid), 0);
    check("rst_tx_done",  32'(o_tx_done), 0);
    check("rst_tx_acked", 32'(o_tx_acked), 0);
    check("rst_busy",     32'(o_busy), 0);
    check("rst_sda",      32'(sda_bus), 1);
    clks(5);
    i_rst = 1'b0;
    clks(5);

    // Basic write, wrong address, reads with NACK and ACK.
    do_write(SLV, 8'hA5);
    check("rx_byte_hold", 32'(o_rx_byte), 32'hA5);
    do_write(7'h43, 8'h77);
    do_read(8'h3C, 1'b0);
    do_read(8'h3C, 1'b1);

    // Repeated START after 4 data bits discards the partial byte.
    start_cond();
    send_byte({SLV, RW_WRITE}, a);
    check("rs_addr_ack", 32'(a), 32'(ACK));
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), r);
    i_tx_byte = 8'hC3;
    start_cond();
    read_body(8'hC3, 1'b1);

    // Reset while the target is driving a 0 data bit.
    i_tx_byte = 8'h00;
    start_cond();
    send_byte({SLV, RW_READ}, a);
    check("rst_tst_addr_ack", 32'(a), 32'(ACK));
    bit_xfer(1'b1, r);
    bit_xfer(1'b1, r);
    clks(HALF / 2 + 1);
    check("tx_driving_low", 32'(sda_bus), 0);
    i_rst = 1'b1;
    #1;
    check("midrst_sda",      32'(sda_bus), 1);
    check("midrst_rx_byte",  32'(o_rx_byte), 0);
    check("midrst_tx_acked", 32'(o_tx_acked), 0);
    check("midrst_busy",     32'(o_busy), 0);
    clks(3);
    i_rst = 1'b0;
    clks(2);
    stop_cond();
    do_write(SLV, 8'h5A);

    // Disabled target ignores a matching write; normal again once enabled.
    i_enable = 1'b0;
    do_write(SLV, 8'h11);
    i_enable = 1'b1;
    clks(4);
    do_write(SLV, 8'h22);

    // Randomized mix.
    for (int n = 0; n < 12; n++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        do_write(SLV, 8'($urandom));
      end else if (kind == 1) begin
        addr = 7'($urandom);
        do_write(addr, 8'($urandom));
      end else begin
        do_read(8'($urandom), 1'($urandom));
      end
    end

    clks(20);
    check("rx_q_drained", 32'(rx_q.size()), 0);
    check("tx_q_drained", 32'(tx_q.size()), 0);
    check("final_busy",   32'(o_busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time bound in case the bench stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
